memrq_arbiter: RTL and testbench

- Shares one memory-request bridge (single-outstanding req/resp memrq interface, AXI-Lite behind it) between two requesters: port 0 = instruction fetch, port 1 = data load/store.
- Latches pulse-style requests per port, grants one at a time, forwards the request as a one-cycle pulse, and routes the single response pulse back to the owning port.
- Sits between the core front-end/LSU and the AXI bridge.

---
 rtl/memrq_pkg.sv | 23 ++
 rtl/memrq_req_slot.sv | 33 +++
 rtl/memrq_arbiter.sv | 176 +++++++++++++++++
 tb/tb_memrq_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/memrq_pkg.sv
// Shared types for the memrq request arbiter slice.
// Request bundle, arbiter state encoding and mode codes.
package memrq_pkg;

   localparam int MEMRQ_ADDR_W = 32;
   localparam int MEMRQ_DATA_W = 32;

   localparam logic MEMREQ_READ  = 1'b0;
   localparam logic MEMREQ_WRITE = 1'b1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } arb_state_t;

   typedef struct packed {
      logic                      mode;
      logic [MEMRQ_ADDR_W-1:0]   addr;
      logic [MEMRQ_DATA_W-1:0]   wdata;
      logic [MEMRQ_DATA_W/8-1:0] wstrb;
   } memrq_req_t;

endpackage

// File: rtl/memrq_req_slot.sv
// One-entry pending request buffer for a single requester.
// New pulses are dropped while an entry waits or the port owns the bus.
module memrq_req_slot
   import memrq_pkg::*;
#(
   parameter type req_t = memrq_req_t
) (
   input  logic clk,
   input  logic rstn,
   input  logic req_en,
   input  req_t req_in,
   input  logic owned,
   input  logic take,
   output logic pend,
   output req_t req_q
);

   // Capture a request only when the port has nothing outstanding.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         pend  <= 1'b0;
         req_q <= '0;
      end else begin
         if (take)
            pend <= 1'b0;
         if (req_en && !pend && !owned) begin
            pend  <= 1'b1;
            req_q <= req_in;
         end
      end
   end

endmodule

// File: rtl/memrq_arbiter.sv
// Two-port arbiter sharing one single-outstanding memrq bridge.
// Define ARB_ROUND_ROBIN_EN for round-robin; default is port 1 priority.
module memrq_arbiter
   import memrq_pkg::*;
#(
   parameter int ADDR_W = MEMRQ_ADDR_W,
   parameter int DATA_W = MEMRQ_DATA_W
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                s0_req_en,
   input  logic                s0_req_mode,
   input  logic [ADDR_W-1:0]   s0_req_addr,
   input  logic [DATA_W-1:0]   s0_req_wdata,
   input  logic [DATA_W/8-1:0] s0_req_wstrb,
   input  logic                s1_req_en,
   input  logic                s1_req_mode,
   input  logic [ADDR_W-1:0]   s1_req_addr,
   input  logic [DATA_W-1:0]   s1_req_wdata,
   input  logic [DATA_W/8-1:0] s1_req_wstrb,
   output logic                s0_resp_en,
   output logic [DATA_W-1:0]   s0_resp_data,
   output logic                s0_busy,
   output logic                s1_resp_en,
   output logic [DATA_W-1:0]   s1_resp_data,
   output logic                s1_busy,
   output logic                m_req_en,
   output logic                m_req_mode,
   output logic [ADDR_W-1:0]   m_req_addr,
   output logic [DATA_W-1:0]   m_req_wdata,
   output logic [DATA_W/8-1:0] m_req_wstrb,
   input  logic                m_resp_en,
   input  logic [DATA_W-1:0]   m_resp_data
);

   localparam int STRB_W = DATA_W / 8;

   typedef struct packed {
      logic              mode;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [STRB_W-1:0] wstrb;
   } req_t;

   req_t s0_in, s1_in, s0_q, s1_q;
   req_t fwd_q, fwd_d;
   logic pend0, pend1;
   logic take0, take1;
   logic own0, own1;
   logic win;

   arb_state_t state_q, state_d;
   logic owner_q, owner_d;
   logic req_en_d;
   logic r0_en_d, r1_en_d;
   logic [DATA_W-1:0] r0_data_d, r1_data_d;

   assign s0_in = {s0_req_mode, s0_req_addr, s0_req_wdata, s0_req_wstrb};
   assign s1_in = {s1_req_mode, s1_req_addr, s1_req_wdata, s1_req_wstrb};

   assign own0 = (state_q == ST_WAIT) && !owner_q;
   assign own1 = (state_q == ST_WAIT) && owner_q;

   assign s0_busy = pend0 | own0;
   assign s1_busy = pend1 | own1;

   assign m_req_mode  = fwd_q.mode;
   assign m_req_addr  = fwd_q.addr;
   assign m_req_wdata = fwd_q.wdata;
   assign m_req_wstrb = fwd_q.wstrb;

   memrq_req_slot #(.req_t(req_t)) u_slot0 (
      .clk    (clk),
      .rstn   (rstn),
      .req_en (s0_req_en),
      .req_in (s0_in),
      .owned  (own0),
      .take   (take0),
      .pend   (pend0),
      .req_q  (s0_q)
   );

   memrq_req_slot #(.req_t(req_t)) u_slot1 (
      .clk    (clk),
      .rstn   (rstn),
      .req_en (s1_req_en),
      .req_in (s1_in),
      .owned  (own1),
      .take   (take1),
      .pend   (pend1),
      .req_q  (s1_q)
   );

`ifdef ARB_ROUND_ROBIN_EN
   logic last_q;

   // On contention the port that was not granted last time wins.
   always_comb begin
      win = pend1;
      if (pend0 && pend1)
         win = ~last_q;
   end

   // Remember the most recent grantee on every grant.
   always_ff @(posedge clk) begin
      if (!rstn)
         last_q <= 1'b0;
      else if (state_q == ST_IDLE && (pend0 || pend1))
         last_q <= win;
   end
`else
   assign win = pend1;
`endif

   // Next-state, grant and response routing.
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      fwd_d     = fwd_q;
      req_en_d  = 1'b0;
      r0_en_d   = 1'b0;
      r1_en_d   = 1'b0;
      r0_data_d = s0_resp_data;
      r1_data_d = s1_resp_data;
      take0     = 1'b0;
      take1     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (pend0 || pend1) begin
               req_en_d = 1'b1;
               owner_d  = win;
               fwd_d    = win ? s1_q : s0_q;
               take0    = ~win;
               take1    = win;
               state_d  = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (m_resp_en) begin
               if (owner_q) begin
                  r1_en_d   = 1'b1;
                  r1_data_d = m_resp_data;
               end else begin
                  r0_en_d   = 1'b1;
                  r0_data_d = m_resp_data;
               end
               state_d = ST_IDLE;
            end
         end
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q      <= ST_IDLE;
         owner_q      <= 1'b0;
         fwd_q        <= '0;
         m_req_en     <= 1'b0;
         s0_resp_en   <= 1'b0;
         s1_resp_en   <= 1'b0;
         s0_resp_data <= '0;
         s1_resp_data <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         fwd_q        <= fwd_d;
         m_req_en     <= req_en_d;
         s0_resp_en   <= r0_en_d;
         s1_resp_en   <= r1_en_d;
         s0_resp_data <= r0_data_d;
         s1_resp_data <= r1_data_d;
      end
   end

endmodule

// File: tb/tb_memrq_arbiter.sv
// Directed bench for memrq_arbiter.
// Honours ARB_ROUND_ROBIN_EN for the contention ordering.
module tb_memrq_arbiter;

   logic        clk;
   logic        rstn;
   logic        s0_req_en, s1_req_en;
   logic        s0_req_mode, s1_req_mode;
   logic [31:0] s0_req_addr, s1_req_addr;
   logic [31:0] s0_req_wdata, s1_req_wdata;
   logic [3:0]  s0_req_wstrb, s1_req_wstrb;
   logic        s0_resp_en, s1_resp_en;
   logic [31:0] s0_resp_data, s1_resp_data;
   logic        s0_busy, s1_busy;
   logic        m_req_en, m_req_mode;
   logic [31:0] m_req_addr, m_req_wdata;
   logic [3:0]  m_req_wstrb;
   logic        m_resp_en;
   logic [31:0] m_resp_data;

   int total;
   int passed;
   int fails;
   int cnt;

`ifdef ARB_ROUND_ROBIN_EN
   localparam bit P1_FIRST = 1'b0;
`else
   localparam bit P1_FIRST = 1'b1;
`endif

   memrq_arbiter dut (
      .clk          (clk),
      .rstn         (rstn),
      .s0_req_en    (s0_req_en),
      .s0_req_mode  (s0_req_mode),
      .s0_req_addr  (s0_req_addr),
      .s0_req_wdata (s0_req_wdata),
      .s0_req_wstrb (s0_req_wstrb),
      .s1_req_en    (s1_req_en),
      .s1_req_mode  (s1_req_mode),
      .s1_req_addr  (s1_req_addr),
      .s1_req_wdata (s1_req_wdata),
      .s1_req_wstrb (s1_req_wstrb),
      .s0_resp_en   (s0_resp_en),
      .s0_resp_data (s0_resp_data),
      .s0_busy      (s0_busy),
      .s1_resp_en   (s1_resp_en),
      .s1_resp_data (s1_resp_data),
      .s1_busy      (s1_busy),
      .m_req_en     (m_req_en),
      .m_req_mode   (m_req_mode),
      .m_req_addr   (m_req_addr),
      .m_req_wdata  (m_req_wdata),
      .m_req_wstrb  (m_req_wstrb),
      .m_resp_en    (m_resp_en),
      .m_resp_data  (m_resp_data)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      total = 0;
      passed = 0;
      fails = 0;
      rstn = 1'b0;
      s0_req_en = 0; s0_req_mode = 0; s0_req_addr = 0;
      s0_req_wdata = 0; s0_req_wstrb = 0;
      s1_req_en = 0; s1_req_mode = 0; s1_req_addr = 0;
      s1_req_wdata = 0; s1_req_wstrb = 0;
      m_resp_en = 0; m_resp_data = 0;
      tick();
      tick();
      chk("rst_mreq", m_req_en, 0);
      chk("rst_addr", m_req_addr, 0);
      chk("rst_busy", {s1_busy, s0_busy}, 0);
      chk("rst_resp", {s1_resp_en, s0_resp_en}, 0);
      chk("rst_data", s0_resp_data, 0);
      rstn = 1'b1;
      tick();

      // single read on port 0
      s0_req_en = 1; s0_req_mode = 0; s0_req_addr = 32'h0000_1000;
      tick();
      s0_req_en = 0;
      chk("rd_pend_busy", s0_busy, 1);
      chk("rd_t1_mreq", m_req_en, 0);
      tick();
      chk("rd_t2_mreq", m_req_en, 1);
      chk("rd_mode", m_req_mode, 0);
      chk("rd_addr", m_req_addr, 32'h0000_1000);
      tick();
      chk("rd_pulse_end", m_req_en, 0);
      m_resp_en = 1; m_resp_data = 32'hDEAD_BEEF;
      tick();
      m_resp_en = 0;
      chk("rd_resp", {s1_resp_en, s0_resp_en}, 2'b01);
      chk("rd_data", s0_resp_data, 32'hDEAD_BEEF);
      chk("rd_busy_fall", s0_busy, 0);
      tick();
      chk("rd_resp_1cyc", s0_resp_en, 0);
      chk("rd_data_hold", s0_resp_data, 32'hDEAD_BEEF);

      // write on port 1
      s1_req_en = 1; s1_req_mode = 1; s1_req_addr = 32'h2000;
      s1_req_wdata = 32'h1234_5678; s1_req_wstrb = 4'h3;
      tick();
      s1_req_en = 0;
      tick();
      chk("wr_mreq", m_req_en, 1);
      chk("wr_fwd", {m_req_mode, m_req_addr, m_req_wdata, m_req_wstrb},
          {1'b1, 32'h2000, 32'h1234_5678, 4'h3});
      tick();
      chk("wr_busy_wait", s1_busy, 1);
      chk("wr_hold_addr", m_req_addr, 32'h2000);
      m_resp_en = 1; m_resp_data = 32'h0;
      tick();
      m_resp_en = 0;
      chk("wr_resp", {s1_resp_en, s0_resp_en}, 2'b10);
      chk("wr_busy_fall", s1_busy, 0);
      tick();

      // simultaneous reads
      s0_req_en = 1; s0_req_mode = 0; s0_req_addr = 32'h100;
      s1_req_en = 1; s1_req_mode = 0; s1_req_addr = 32'h200;
      tick();
      s0_req_en = 0; s1_req_en = 0;
      chk("sim_busy", {s1_busy, s0_busy}, 2'b11);
      tick();
      chk("sim_g1_en", m_req_en, 1);
      chk("sim_g1_addr", m_req_addr, P1_FIRST ? 32'h200 : 32'h100);
      tick();
      m_resp_en = 1; m_resp_data = 32'hAAAA_0001;
      tick();
      m_resp_en = 0;
      chk("sim_r1_port", {s1_resp_en, s0_resp_en}, P1_FIRST ? 2'b10 : 2'b01);
      chk("sim_r1_nogrant", m_req_en, 0);
      tick();
      chk("sim_g2_en", m_req_en, 1);
      chk("sim_g2_addr", m_req_addr, P1_FIRST ? 32'h100 : 32'h200);
      tick();
      m_resp_en = 1; m_resp_data = 32'hBBBB_0002;
      tick();
      m_resp_en = 0;
      chk("sim_r2_port", {s1_resp_en, s0_resp_en}, P1_FIRST ? 2'b01 : 2'b10);
      chk("sim_r1_hold", P1_FIRST ? s1_resp_data : s0_resp_data, 32'hAAAA_0001);
      chk("sim_r2_data", P1_FIRST ? s0_resp_data : s1_resp_data, 32'hBBBB_0002);
      tick();

      // drop while in flight
      s0_req_en = 1; s0_req_addr = 32'h40;
      tick();
      s0_req_en = 0;
      tick();
      chk("drop_g_addr", m_req_addr, 32'h40);
      tick();
      s0_req_en = 1; s0_req_addr = 32'h44;
      tick();
      s0_req_en = 0;
      chk("drop_owned_busy", s0_busy, 1);
      m_resp_en = 1; m_resp_data = 32'h5;
      tick();
      m_resp_en = 0;
      chk("drop_resp", s0_resp_en, 1);
      chk("drop_busy_clear", s0_busy, 0);
      cnt = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (m_req_en) cnt++;
      end
      chk("drop_no_regrant", cnt, 0);
      chk("drop_addr", m_req_addr, 32'h40);

      // reset during WAIT, stray response afterwards
      s1_req_en = 1; s1_req_mode = 0; s1_req_addr = 32'h300;
      tick();
      s1_req_en = 0;
      tick();
      chk("rw_grant", m_req_en, 1);
      tick();
      rstn = 0;
      tick();
      rstn = 1;
      m_resp_en = 1; m_resp_data = 32'hCAFE_0000;
      tick();
      m_resp_en = 0;
      chk("rw_no_resp", {s1_resp_en, s0_resp_en}, 0);
      chk("rw_outs", {m_req_en, m_req_mode, m_req_addr, s1_busy, s0_busy}, 0);
      chk("rw_data0", {s1_resp_data, s0_resp_data}, 0);
      s0_req_en = 1; s0_req_mode = 0; s0_req_addr = 32'h500;
      tick();
      s0_req_en = 0;
      tick();
      chk("rw_next_grant", {m_req_en, m_req_addr}, {1'b1, 32'h500});
      tick();
      m_resp_en = 1; m_resp_data = 32'h7777_0000;
      tick();
      m_resp_en = 0;
      chk("rw_next_resp", {s0_resp_en, s0_resp_data}, {1'b1, 32'h7777_0000});
      tick();

      // back-to-back re-request in the response cycle
      s0_req_en = 1; s0_req_addr = 32'h600;
      tick();
      s0_req_en = 0;
      tick();
      chk("b2b_g1", {m_req_en, m_req_addr}, {1'b1, 32'h600});
      cnt = 0;
      tick(); cnt++;
      tick(); cnt++;
      m_resp_en = 1; m_resp_data = 32'h1;
      tick(); cnt++;
      m_resp_en = 0;
      chk("b2b_resp", s0_resp_en, 1);
      s0_req_en = 1; s0_req_addr = 32'h604;
      tick(); cnt++;
      s0_req_en = 0;
      chk("b2b_pend", {m_req_en, s0_busy}, 2'b01);
      tick(); cnt++;
      chk("b2b_g2", {m_req_en, m_req_addr}, {1'b1, 32'h604});
      chk("b2b_period", cnt, 5);
      tick();
      m_resp_en = 1;
      tick();
      m_resp_en = 0;
      tick();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
